// File: rtl/instr_memory_if.sv
// Instruction memory port: the fetch unit drives addr, memory returns instr in the same cycle.
interface instr_memory_if;
    logic [31:0] addr;
    logic [31:0] instr;

    modport master (output addr, input instr);
    modport slave  (input addr, output instr);
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: sequential PC generation into a small registered buffer,
// with redirect/flush, halt-and-drain and a misaligned-target pulse.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    instr_memory_if.master        instr_mem_if,
    input  logic                  redirect_valid,
    input  logic [31:0]           redirect_pc,
    input  logic                  halt,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [31:0]           out_instr,
    output logic [31:0]           out_pc,
    output logic                  misalign_pulse,
    output logic [1:0]            fsm_state
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {
        BOOT   = 2'd0,
        FETCH  = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t          state, state_nxt;
    logic [31:0]     fetch_pc;
    logic [31:0]     buf_pc    [FIFO_DEPTH];
    logic [31:0]     buf_instr [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr, rd_ptr;
    logic [CW-1:0]   count;
    logic            push, pop, flush;

    // Handshake: an entry transfers on any rising edge where out_valid && out_ready;
    // the head stays put otherwise. A redirect flushes even the entry being popped.
    assign pop               = out_valid && out_ready;
    assign out_valid         = (count != '0);
    assign out_pc            = buf_pc[rd_ptr];
    assign out_instr         = buf_instr[rd_ptr];
    assign instr_mem_if.addr = fetch_pc;
    assign fsm_state         = state;

    always_comb begin
        state_nxt = state;
        push      = 1'b0;
        flush     = 1'b0;
        case (state)
            BOOT: state_nxt = FETCH;
            FETCH: begin
                flush = redirect_valid;
                push  = !redirect_valid && ((count < CW'(FIFO_DEPTH)) || pop);
                if (halt && !redirect_valid) state_nxt = HALTED;
            end
            HALTED: begin
                flush = redirect_valid;
                if (!halt || redirect_valid) state_nxt = FETCH;
            end
            default: state_nxt = BOOT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= BOOT;
            fetch_pc       <= RESET_PC;
            count          <= '0;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            misalign_pulse <= 1'b0;
        end else begin
            state          <= state_nxt;
            misalign_pulse <= flush && (redirect_pc[1:0] != 2'b00);
            if (flush) begin
                fetch_pc <= {redirect_pc[31:2], 2'b00};
                count    <= '0;
                wr_ptr   <= '0;
                rd_ptr   <= '0;
            end else begin
                if (push) begin
                    fetch_pc <= fetch_pc + 32'd4;
                    wr_ptr   <= wr_ptr + PW'(1);
                end
                if (pop) rd_ptr <= rd_ptr + PW'(1);
                if (push && !pop)      count <= count + CW'(1);
                else if (pop && !push) count <= count - CW'(1);
            end
        end
    end

    // Storage is cleared on reset so the head reads zero while the block is held in reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                buf_pc[i]    <= '0;
                buf_instr[i] <= '0;
            end
        end else if (push) begin
            buf_pc[wr_ptr]    <= fetch_pc;
            buf_instr[wr_ptr] <= instr_mem_if.instr;
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: one instance at RESET_PC=0, one at 0xFFFFFFF8 for wrap.
module tb_instr_fetch_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int tests_run    = 0;
    int tests_failed = 0;
    logic [31:0] exp_q[$];

    // Instance A signals
    logic        rst_n = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        halt = 1'b0;
    logic        out_ready = 1'b0;
    logic        out_valid, misalign_pulse;
    logic [31:0] out_instr, out_pc;
    logic [1:0]  fsm_state;

    // Instance B signals
    logic        rst_n_b = 1'b0;
    logic        halt_b = 1'b0;
    logic        out_ready_b = 1'b0;
    logic        out_valid_b, misalign_pulse_b;
    logic [31:0] out_instr_b, out_pc_b;
    logic [1:0]  fsm_state_b;

    instr_memory_if mem_a ();
    instr_memory_if mem_b ();

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0)      return 32'h0000_0013;
        else if (a == 32'h4) return 32'h0010_0093;
        else                 return ~a;
    endfunction

    assign mem_a.instr = mem_word(mem_a.addr);
    assign mem_b.instr = mem_word(mem_b.addr);

    instr_fetch_unit #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(2)) dut_a (
        .clk(clk), .rst_n(rst_n), .instr_mem_if(mem_a.master),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .halt(halt),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
        .out_pc(out_pc), .misalign_pulse(misalign_pulse), .fsm_state(fsm_state)
    );

    instr_fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .FIFO_DEPTH(2)) dut_b (
        .clk(clk), .rst_n(rst_n_b), .instr_mem_if(mem_b.master),
        .redirect_valid(1'b0), .redirect_pc(32'h0), .halt(halt_b),
        .out_valid(out_valid_b), .out_ready(out_ready_b), .out_instr(out_instr_b),
        .out_pc(out_pc_b), .misalign_pulse(misalign_pulse_b), .fsm_state(fsm_state_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    initial begin
        // Reset state
        tick();
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_pc", out_pc, 32'h0);
        check("rst_instr", out_instr, 32'h0);
        check("rst_misalign", 32'(misalign_pulse), 32'd0);
        check("rst_addr", mem_a.addr, 32'h0);
        check("rst_state", 32'(fsm_state), 32'd0);

        // Basic streaming from RESET_PC
        rst_n = 1'b1; out_ready = 1'b1;
        tick();
        check("boot_novalid", 32'(out_valid), 32'd0);
        check("boot_to_fetch", 32'(fsm_state), 32'd1);
        tick();
        check("s0_valid", 32'(out_valid), 32'd1);
        check("s0_pc", out_pc, 32'h0);
        check("s0_instr", out_instr, 32'h0000_0013);
        tick();
        check("s1_pc", out_pc, 32'h4);
        check("s1_instr", out_instr, 32'h0010_0093);

        // Backpressure from a fresh reset
        rst_n = 1'b0; out_ready = 1'b0;
        tick();
        rst_n = 1'b1;
        tick(2);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_hold_pc", out_pc, 32'h0);
        end
        check("bp_addr_stop", mem_a.addr, 32'h8);
        check("bp_count_full", 32'(dut_a.count), 32'd2);
        exp_q.push_back(32'h0); exp_q.push_back(32'h4); exp_q.push_back(32'h8);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check("bp_deliver_valid", 32'(out_valid), 32'd1);
            check("bp_deliver_pc", out_pc, exp_q.pop_front());
            tick();
        end

        // Redirect while full
        out_ready = 1'b0;
        tick(2);
        check("rd_full_valid", 32'(out_valid), 32'd1);
        redirect_valid = 1'b1; redirect_pc = 32'h40; out_ready = 1'b1;
        tick();
        redirect_valid = 1'b0;
        check("rd_flush_valid", 32'(out_valid), 32'd0);
        check("rd_addr", mem_a.addr, 32'h40);
        check("rd_no_misalign", 32'(misalign_pulse), 32'd0);
        tick();
        check("rd_first_pc", out_pc, 32'h40);
        check("rd_first_instr", out_instr, ~32'h40);
        tick();
        check("rd_second_pc", out_pc, 32'h44);

        // Misaligned redirect
        redirect_valid = 1'b1; redirect_pc = 32'h46;
        tick();
        redirect_valid = 1'b0;
        check("mis_pulse_hi", 32'(misalign_pulse), 32'd1);
        check("mis_flush", 32'(out_valid), 32'd0);
        check("mis_addr", mem_a.addr, 32'h44);
        tick();
        check("mis_pulse_lo", 32'(misalign_pulse), 32'd0);
        check("mis_pc", out_pc, 32'h44);

        // Mid-operation asynchronous reset with two entries held
        out_ready = 1'b0;
        tick(2);
        check("mr_valid_before", 32'(out_valid), 32'd1);
        check("mr_count_before", 32'(dut_a.count), 32'd2);
        #2 rst_n = 1'b0;
        #1;
        check("mr_async_valid", 32'(out_valid), 32'd0);
        check("mr_async_addr", mem_a.addr, 32'h0);
        check("mr_async_state", 32'(fsm_state), 32'd0);
        tick();
        rst_n = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h80;
        tick();
        redirect_valid = 1'b0;
        check("boot_redirect_ignored", mem_a.addr, 32'h0);
        check("boot_redirect_nomis", 32'(misalign_pulse), 32'd0);
        check("mr_restart_novalid", 32'(out_valid), 32'd0);
        tick();
        check("mr_restart_pc", out_pc, 32'h0);
        check("mr_restart_valid", 32'(out_valid), 32'd1);

        // Halt, drain and wrap on instance B
        rst_n_b = 1'b1;
        tick();
        halt_b = 1'b1;
        tick();
        check("hw_first_pc", out_pc_b, 32'hFFFF_FFF8);
        check("hw_addr_hold", mem_b.addr, 32'hFFFF_FFFC);
        check("hw_halted", 32'(fsm_state_b), 32'd2);
        out_ready_b = 1'b1;
        tick();
        check("hw_drained", 32'(out_valid_b), 32'd0);
        tick(2);
        check("hw_addr_still", mem_b.addr, 32'hFFFF_FFFC);
        check("hw_still_empty", 32'(out_valid_b), 32'd0);
        halt_b = 1'b0;
        tick();
        check("hw_resume_state", 32'(fsm_state_b), 32'd1);
        tick();
        check("hw_pc_fffc", out_pc_b, 32'hFFFF_FFFC);
        tick();
        check("hw_pc_wrap", out_pc_b, 32'h0000_0000);
        check("hw_addr_after_wrap", mem_b.addr, 32'h4);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
